// File: rtl/pu_pkg.sv
// -----------------------------------------------------------------------------
// pu_pkg
// Shared definitions for generic_processing_unit and its sequential divider:
//   - ALU opcode encodings
//   - divider FSM state type
//   - is_legal_op() helper, which tells whether an opcode is one the unit executes
// -----------------------------------------------------------------------------
package pu_pkg;

    localparam logic [7:0] OP_ADD = 8'h05;
    localparam logic [7:0] OP_SUB = 8'h06;
    localparam logic [7:0] OP_MUL = 8'h07;
    localparam logic [7:0] OP_DIV = 8'h08;
    localparam logic [7:0] OP_NOT = 8'h09;
    localparam logic [7:0] OP_OR  = 8'h0A;
    localparam logic [7:0] OP_XOR = 8'h0B;
    localparam logic [7:0] OP_AND = 8'h0C;
    localparam logic [7:0] OP_SHL = 8'h15;
    localparam logic [7:0] OP_SHR = 8'h16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } div_state_e;

    function automatic logic is_legal_op(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_NOT,
            OP_OR,  OP_XOR, OP_AND, OP_SHL, OP_SHR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider that produces one quotient bit per clock.
// A start with a nonzero divisor runs WIDTH iterations in ST_DIV.
// A start with a zero divisor finishes at once:
//   quotient  = all ones
//   remainder = dividend
//   err       = 1
// Ports:
//   clk, rstn            clock; asynchronous active-low reset
//   start                load the operands; only honoured while idle
//   dividend, divisor    operands (WIDTH bits each)
//   busy                 iteration in progress
//   done                 one-cycle pulse when new results are presented
//   finish               combinational: results update at the coming edge
//   quotient, remainder  results; held until the next completion
//   err                  last completion was a divide-by-zero
// -----------------------------------------------------------------------------
module seq_divider
    import pu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             finish,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out MSB-first, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Datapath for one restoring step.
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    always_comb begin
        partial  = {rem_q, quo_q[WIDTH-1]};
        trial    = partial - {1'b0, dvs_q};
        fits     = (partial >= {1'b0, dvs_q});
        // The remainder stays below the divisor, so a successful trial fits in WIDTH bits.
        step_rem = fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], fits};
    end

    // NOTE: every always_comb output gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        err_d       = err_q;
        done_d      = 1'b0;
        finish      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        err_d       = 1'b1;
                        done_d      = 1'b1;
                        finish      = 1'b1;
                    end else begin
                        state_d = ST_DIV;
                        count_d = CW'(WIDTH);
                        rem_d   = '0;
                        quo_d   = dividend;
                        dvs_d   = divisor;
                    end
                end
            end
            ST_DIV: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d     = ST_IDLE;
                    quotient_d  = step_quo;
                    remainder_d = step_rem;
                    err_d       = 1'b0;
                    done_d      = 1'b1;
                    finish      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops update
    // together at the edge, whatever order the statements are written in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q == ST_DIV);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign err       = err_q;

endmodule

// File: rtl/generic_processing_unit.sv
// -----------------------------------------------------------------------------
// generic_processing_unit
// Small ALU. Every operation except division completes one cycle after start
// is accepted. Division is handed to seq_divider, which runs one bit per clock.
// Ports:
//   clk, rstn            clock; asynchronous active-low reset
//   start                request; accepted when busy=0
//   alu_opcode           operation select (see pu_pkg)
//   acc_data             operand A / dividend
//   rd_data              operand B / divisor / shift amount
//   busy                 division in progress (start ignored)
//   done                 one-cycle completion pulse
//   res_out              2*WIDTH result; {remainder, quotient} after a division
//   quotient, remainder  division results; only a division updates them
//   z, ci_alu, err       zero, carry/borrow, illegal-op or divide-by-zero
// -----------------------------------------------------------------------------
module generic_processing_unit
    import pu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(2 * WIDTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [7:0]         alu_opcode,
    input  logic [WIDTH-1:0]   acc_data,
    input  logic [WIDTH-1:0]   rd_data,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] res_out,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               z,
    output logic               ci_alu,
    output logic               err
);

    logic             accept;
    logic             is_div_op;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic             div_finish;
    logic             div_err;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    assign accept    = start && !div_busy;
    assign is_div_op = (alu_opcode == OP_DIV);
    assign div_start = accept && is_div_op;

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .start     (div_start),
        .dividend  (acc_data),
        .divisor   (rd_data),
        .busy      (div_busy),
        .done      (div_done),
        .finish    (div_finish),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .err       (div_err)
    );

    // Single-cycle operations.
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] alu_res;
    logic               alu_ci;
    logic               alu_err;

    always_comb begin
        a_ext   = {{WIDTH{1'b0}}, acc_data};
        b_ext   = {{WIDTH{1'b0}}, rd_data};
        alu_res = '0;
        alu_ci  = 1'b0;
        alu_err = !is_legal_op(alu_opcode);

        case (alu_opcode)
            OP_ADD: begin
                alu_res = a_ext + b_ext;
                alu_ci  = alu_res[WIDTH];
            end
            OP_SUB: begin
                alu_res = {{WIDTH{1'b0}}, acc_data - rd_data};
                alu_ci  = (acc_data < rd_data);
            end
            // The upper halves of both operands are zero, so the truncated product is exact.
            OP_MUL:  alu_res = a_ext * b_ext;
            OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~acc_data};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, acc_data | rd_data};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, acc_data ^ rd_data};
            OP_AND:  alu_res = {{WIDTH{1'b0}}, acc_data & rd_data};
            OP_SHL:  alu_res = a_ext << rd_data[SHW-1:0];
            OP_SHR:  alu_res = a_ext >> rd_data[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // Result registers for single-cycle ops. src_div_q selects whether the
    // outputs reflect the divider or these registers. It switches to the divider
    // only at the edge where the divider presents new results. During a division
    // the outputs therefore keep showing the previous result.
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               z_q, z_d;
    logic               ci_q, ci_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               src_div_q, src_div_d;

    always_comb begin
        res_d     = res_q;
        z_d       = z_q;
        ci_d      = ci_q;
        err_d     = err_q;
        done_d    = 1'b0;
        src_div_d = src_div_q;

        if (accept && !is_div_op) begin
            res_d     = alu_res;
            z_d       = (alu_res == '0);
            ci_d      = alu_ci;
            err_d     = alu_err;
            done_d    = 1'b1;
            src_div_d = 1'b0;
        end

        if (div_finish) begin
            src_div_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_q     <= '0;
            z_q       <= 1'b0;
            ci_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            src_div_q <= 1'b0;
        end else begin
            res_q     <= res_d;
            z_q       <= z_d;
            ci_q      <= ci_d;
            err_q     <= err_d;
            done_q    <= done_d;
            src_div_q <= src_div_d;
        end
    end

    assign busy      = div_busy;
    assign done      = done_q | div_done;
    assign quotient  = div_quotient;
    assign remainder = div_remainder;
    assign res_out   = src_div_q ? {div_remainder, div_quotient} : res_q;
    assign z         = src_div_q ? (div_quotient == '0) : z_q;
    assign ci_alu    = src_div_q ? 1'b0 : ci_q;
    assign err       = src_div_q ? div_err : err_q;

endmodule

// File: tb/tb_generic_processing_unit.sv
// -----------------------------------------------------------------------------
// tb_generic_processing_unit
// Directed tests with hand-computed expectations.
// Instantiates the unit twice: WIDTH=8 (dut) and WIDTH=16 (dut16).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_generic_processing_unit;

    logic        clk;
    logic        rstn;

    logic        start;
    logic [7:0]  alu_opcode;
    logic [7:0]  acc_data;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic [15:0] res_out;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        z;
    logic        ci_alu;
    logic        err;

    logic        start16;
    logic [7:0]  alu_opcode16;
    logic [15:0] acc_data16;
    logic [15:0] rd_data16;
    logic        busy16;
    logic        done16;
    logic [31:0] res_out16;
    logic [15:0] quotient16;
    logic [15:0] remainder16;
    logic        z16;
    logic        ci_alu16;
    logic        err16;

    int n_cmp = 0;
    int n_err = 0;

    generic_processing_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .alu_opcode (alu_opcode),
        .acc_data   (acc_data),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .res_out    (res_out),
        .quotient   (quotient),
        .remainder  (remainder),
        .z          (z),
        .ci_alu     (ci_alu),
        .err        (err)
    );

    generic_processing_unit #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start16),
        .alu_opcode (alu_opcode16),
        .acc_data   (acc_data16),
        .rd_data    (rd_data16),
        .busy       (busy16),
        .done       (done16),
        .res_out    (res_out16),
        .quotient   (quotient16),
        .remainder  (remainder16),
        .z          (z16),
        .ci_alu     (ci_alu16),
        .err        (err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request for a single clock on the 8-bit unit.
    // Returns at the falling edge after the sampling edge, where done is expected.
    task automatic do_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start      = 1'b1;
        alu_opcode = op;
        acc_data   = a;
        rd_data    = b;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Issue a request on the 8-bit unit and count falling edges until done.
    // lat = 0 means done is visible right after the sampling edge.
    // When inject is set, an add request is presented while the division is busy.
    task automatic run_div8(input logic [7:0] a, input logic [7:0] b, input bit inject,
                            output int lat, output int busy_cnt);
        @(negedge clk);
        start      = 1'b1;
        alu_opcode = 8'h08;
        acc_data   = a;
        rd_data    = b;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 64) begin
            if (busy) busy_cnt++;
            if (inject && lat == 2) begin
                start      = 1'b1;
                alu_opcode = 8'h05;
                acc_data   = 8'd1;
                rd_data    = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic run16(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        @(negedge clk);
        start16      = 1'b1;
        alu_opcode16 = op;
        acc_data16   = a;
        rd_data16    = b;
        @(negedge clk);
        start16 = 1'b0;
        lat     = 0;
        while (!done16 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_seen;

        rstn         = 1'b0;
        start        = 1'b0;
        alu_opcode   = 8'h00;
        acc_data     = 8'h00;
        rd_data      = 8'h00;
        start16      = 1'b0;
        alu_opcode16 = 8'h00;
        acc_data16   = 16'h0;
        rd_data16    = 16'h0;

        // Reset state.
        #12;
        check("rst_res_out",   res_out,   16'd0);
        check("rst_done",      done,      1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_quotient",  quotient,  8'd0);
        check("rst_remainder", remainder, 8'd0);
        check("rst_z",         z,         1'b0);
        check("rst_ci",        ci_alu,    1'b0);
        check("rst_err",       err,       1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // add 24+78
        do_op(8'h05, 8'd24, 8'd78);
        check("add_done", done,    1'b1);
        check("add_busy", busy,    1'b0);
        check("add_res",  res_out, 16'd102);
        check("add_ci",   ci_alu,  1'b0);
        check("add_z",    z,       1'b0);
        @(negedge clk);
        check("add_done_pulse", done,    1'b0);
        check("add_hold",       res_out, 16'd102);

        // add with carry out
        do_op(8'h05, 8'd200, 8'd100);
        check("addc_res", res_out, 16'd300);
        check("addc_ci",  ci_alu,  1'b1);

        do_op(8'h06, 8'd24, 8'd78);
        check("sub_res", res_out, 16'd202);
        check("sub_ci",  ci_alu,  1'b1);

        do_op(8'h06, 8'd78, 8'd24);
        check("sub2_res", res_out, 16'd54);
        check("sub2_ci",  ci_alu,  1'b0);

        do_op(8'h07, 8'd24, 8'd78);
        check("mul_res", res_out, 16'd1872);
        check("mul_ci",  ci_alu,  1'b0);

        do_op(8'h07, 8'd255, 8'd255);
        check("mul_max", res_out, 16'hFE01);

        do_op(8'h15, 8'd24, 8'd3);
        check("shl_res", res_out, 16'd192);

        do_op(8'h15, 8'd255, 8'd15);
        check("shl_max", res_out, 16'h8000);

        do_op(8'h16, 8'd24, 8'd3);
        check("shr_res", res_out, 16'd3);

        do_op(8'h0A, 8'hA0, 8'h05);
        check("or_res", res_out, 16'h00A5);

        do_op(8'h0B, 8'd24, 8'd24);
        check("xor_zero_res", res_out, 16'd0);
        check("xor_zero_z",   z,       1'b1);
        check("xor_zero_err", err,     1'b0);

        // div 93/9, with an add presented while busy (must be ignored).
        run_div8(8'd93, 8'd9, 1'b1, lat, bcnt);
        check("div_latency",   lat,       8);
        check("div_busy_cnt",  bcnt,      8);
        check("div_busy_end",  busy,      1'b0);
        check("div_quotient",  quotient,  8'd10);
        check("div_remainder", remainder, 8'd3);
        check("div_res",       res_out,   16'd778);
        check("div_err",       err,       1'b0);
        check("div_ci",        ci_alu,    1'b0);
        check("div_z",         z,         1'b0);

        // Start in the same cycle as done: NOT 24 -> 231.
        start      = 1'b1;
        alu_opcode = 8'h09;
        acc_data   = 8'd24;
        rd_data    = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done",     done,     1'b1);
        check("b2b_not_res",  res_out,  16'd231);
        check("b2b_quot_hold", quotient, 8'd10);

        // Divide by zero.
        run_div8(8'd93, 8'd0, 1'b0, lat, bcnt);
        check("dz_latency",   lat,       0);
        check("dz_busy_cnt",  bcnt,      0);
        check("dz_quotient",  quotient,  8'd255);
        check("dz_remainder", remainder, 8'd93);
        check("dz_res",       res_out,   16'd24063);
        check("dz_err",       err,       1'b1);

        // Illegal opcode.
        do_op(8'h20, 8'd5, 8'd7);
        check("ill_done",      done,      1'b1);
        check("ill_res",       res_out,   16'd0);
        check("ill_z",         z,         1'b1);
        check("ill_err",       err,       1'b1);
        check("ill_ci",        ci_alu,    1'b0);
        check("ill_quot_hold", quotient,  8'd255);
        check("ill_rem_hold",  remainder, 8'd93);

        // Reset in the middle of a division.
        @(negedge clk);
        start      = 1'b1;
        alu_opcode = 8'h08;
        acc_data   = 8'd93;
        rd_data    = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mrst_busy",      busy,      1'b0);
        check("mrst_done",      done,      1'b0);
        check("mrst_res",       res_out,   16'd0);
        check("mrst_quotient",  quotient,  8'd0);
        check("mrst_remainder", remainder, 8'd0);
        check("mrst_z",         z,         1'b0);
        check("mrst_err",       err,       1'b0);
        @(negedge clk);
        rstn      = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("mrst_no_done", done_seen, 0);
        do_op(8'h0C, 8'd24, 8'd78);
        check("mrst_and_done", done,    1'b1);
        check("mrst_and_res",  res_out, 16'd8);

        // WIDTH=16 instance.
        run16(8'h07, 16'hFFFF, 16'hFFFF, lat);
        check("w16_mul_lat", lat,       0);
        check("w16_mul_res", res_out16, 32'hFFFE_0001);

        run16(8'h08, 16'd60000, 16'd7, lat);
        check("w16_div_lat",       lat,         16);
        check("w16_div_quotient",  quotient16,  16'd8571);
        check("w16_div_remainder", remainder16, 16'd3);
        check("w16_div_res",       res_out16,   {16'd3, 16'd8571});

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/generic_processing_unit.md
GENERIC_PROCESSING_UNIT -- requirements
Module: generic_processing_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have parameter SHW, default $clog2(2*WIDTH), shift-amount field width (derived; not overridden).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request strobe; operands and opcode sampled when start=1 and busy=0.
REQ-006 SHALL have port alu_opcode  input  8  operation select.
REQ-007 SHALL have port acc_data  input  WIDTH  operand A / dividend.
REQ-008 SHALL have port rd_data  input  WIDTH  operand B / divisor / shift amount.
REQ-009 SHALL have port busy  output  1  division in progress; new start ignored.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result outputs valid from this cycle on.
REQ-011 SHALL have port res_out  output  2*WIDTH  registered result.
REQ-012 SHALL have port quotient  output  WIDTH; port remainder  output  WIDTH; division results.
REQ-013 SHALL have port z  output  1  zero flag; ci_alu  output  1  carry/borrow flag; err  output  1  illegal opcode or divide-by-zero.

Function
REQ-014 Opcodes SHALL be: 0x05 add, 0x06 sub, 0x07 mul, 0x08 div, 0x09 not, 0x0A or, 0x0B xor, 0x0C and, 0x15 shl, 0x16 shr; all others illegal.
REQ-015 Single-cycle ops: start accepted at edge N -> done=1 and results updated at edge N+1; busy stays 0.
REQ-016 add: res_out = zero-extended (acc+rd) on WIDTH+1 bits; ci_alu = bit WIDTH of sum.
REQ-017 sub: res_out = zero-extended (acc-rd) mod 2^WIDTH; ci_alu = 1 iff acc<rd (borrow).
REQ-018 mul: res_out = full unsigned 2*WIDTH product; ci_alu=0.
REQ-019 not/or/xor/and: bitwise on WIDTH bits (not uses acc only), zero-extended; ci_alu=0.
REQ-020 shl/shr: res_out = zero-extended acc shifted by rd_data[SHW-1:0], truncated to 2*WIDTH; ci_alu=0.
REQ-021 z SHALL equal (res_out==0) for non-div ops; for div, z = (quotient==0).
REQ-022 div: FSM states IDLE -> DIV (WIDTH iterations, one restoring-division bit per cycle) -> IDLE; start at edge N -> busy=1 edges N+1..N+WIDTH, done at edge N+WIDTH+1 with busy=0.
REQ-023 div result: quotient=acc/rd, remainder=acc%rd, res_out={remainder,quotient}, ci_alu=0, err=0.
REQ-024 Divide-by-zero: no iteration; done at N+1, quotient=all ones, remainder=acc, res_out={acc, all ones}, err=1.
REQ-025 Illegal opcode: done at N+1, res_out=0, z=1, ci_alu=0, err=1; quotient/remainder unchanged.
REQ-026 start while busy=1 SHALL be ignored entirely (no queuing, no effect on in-flight division).
REQ-027 start in the same cycle as done (busy=0) SHALL be accepted normally.
REQ-028 All result outputs SHALL hold their value until the next done; quotient/remainder change only on div or divide-by-zero.

Reset
REQ-029 rstn=0 SHALL immediately force FSM=IDLE, busy=0, done=0, res_out=0, quotient=0, remainder=0, z=0, ci_alu=0, err=0.
REQ-030 Reset mid-division SHALL abort it; no done pulse follows; first start after rstn rises is accepted.

Structure
REQ-031 Opcode localparams and FSM state enum SHALL live in shared package pu_pkg.
REQ-032 Division SHALL be a sub-module seq_divider (parameter WIDTH; start/busy/done handshake, quotient/remainder outputs).

Verification (WIDTH=8 unless noted)
REQ-033 add 24+78 -> res_out=102, ci_alu=0, done at N+1; add 200+100 -> res_out=300, ci_alu=1.
REQ-034 sub 24-78 -> res_out=202, ci_alu=1; mul 24*78 -> res_out=1872; shl 24 by 3 -> 192; shr 24 by 3 -> 3.
REQ-035 div 93/9 -> busy N+1..N+8, done at N+9, quotient=10, remainder=3, res_out=778; start 0x05 during busy ignored.
REQ-036 div 93/0 -> done at N+1, quotient=255, remainder=93, err=1; opcode 0x20 -> res_out=0, z=1, err=1.
REQ-037 rstn asserted at N+4 of a division -> all outputs 0, no done; subsequent 24 and 78 (0x0C) -> res_out=8.
REQ-038 WIDTH=16: mul 65535*65535 -> res_out=0xFFFE0001; div 60000/7 -> quotient=8571, remainder=3, done at N+17.
